imem_loader: RTL and testbench



---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_word_packer.sv | 35 +++
 rtl/imem_loader.sv | 158 +++++++++++++++
 tb/tb_imem_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, default NOP word,
// header width and the running-checksum helper.
package imem_pkg;

    typedef enum logic [2:0] {
        ST_HDR0 = 3'd0,
        ST_HDR1 = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
    localparam int          HDR_W     = 16;

    // One step of the payload XOR checksum.
    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream into little-endian 32-bit words; wr_en/wr_data are presented
// combinationally with the fourth byte so the word is written on the accepting edge.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        wr_en,
    output logic [31:0] wr_data
);

    logic [1:0]  lane_r;
    logic [23:0] part_r;

    // Lane counter and the three low bytes of the word under assembly.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lane_r <= 2'd0;
            part_r <= 24'd0;
        end else if (byte_en) begin
            case (lane_r)
                2'd0:    part_r[7:0]   <= byte_data;
                2'd1:    part_r[15:8]  <= byte_data;
                2'd2:    part_r[23:16] <= byte_data;
                default: part_r        <= 24'd0;
            endcase
            lane_r <= lane_r + 2'd1;
        end
    end

    assign wr_en   = byte_en && (lane_r == 2'd3);
    assign wr_data = {byte_data, part_r};

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loaded from a byte stream, holding the core in reset until done.
// Optional payload checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] NOP_INSTR = imem_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    input  logic        reload,
    input  logic [31:0] PC,
    output logic [31:0] Instr,
    output logic        cpu_rst,
    output logic        load_done,
    output logic        load_err
);

    import imem_pkg::*;

    localparam int               AW      = $clog2(DEPTH);
    localparam logic [HDR_W:0]   DEPTH_X = (HDR_W + 1)'(DEPTH);
    localparam logic [29:0]      PC_LIM  = 30'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e ST_AFTER = ST_CHK;
`else
    localparam state_e ST_AFTER = ST_RUN;
`endif

    state_e           state_r, state_nxt_s;
    logic [HDR_W-1:0] n_r;
    logic [AW:0]      wcnt_r;
    logic             cpu_rst_r, load_done_r, load_err_r;
    logic             accept_s, data_en_s, pk_clr_s, wr_en_s;
    logic [31:0]      wr_data_s, instr_s;
    logic [HDR_W-1:0] n_full_s, wcnt_inc_s;
    logic [31:0]      mem_r [DEPTH];
    logic             unused_pc_s;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       chk_r;
`endif

    assign s_ready    = (state_r == ST_HDR0) || (state_r == ST_HDR1) ||
                        (state_r == ST_DATA) || (state_r == ST_CHK);
    assign accept_s   = s_valid && s_ready;
    assign data_en_s  = accept_s && (state_r == ST_DATA);
    assign pk_clr_s   = (state_r != ST_DATA);
    assign n_full_s   = {s_data, n_r[7:0]};
    assign wcnt_inc_s = HDR_W'(wcnt_r) + 16'd1;
    assign unused_pc_s = ^PC[1:0];

    imem_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pk_clr_s),
        .byte_en   (data_en_s),
        .byte_data (s_data),
        .wr_en     (wr_en_s),
        .wr_data   (wr_data_s)
    );

    // Next-state logic of the load sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_HDR0: begin
                if (accept_s) state_nxt_s = ST_HDR1;
                else          state_nxt_s = ST_HDR0;
            end
            ST_HDR1: begin
                if (!accept_s)                       state_nxt_s = ST_HDR1;
                else if (n_full_s == 16'd0)          state_nxt_s = ST_AFTER;
                else if ({1'b0, n_full_s} > DEPTH_X) state_nxt_s = ST_ERR;
                else                                 state_nxt_s = ST_DATA;
            end
            ST_DATA: begin
                if (wr_en_s && (wcnt_inc_s == n_r)) state_nxt_s = ST_AFTER;
                else                                state_nxt_s = ST_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (!accept_s)           state_nxt_s = ST_CHK;
                else if (s_data == chk_r) state_nxt_s = ST_RUN;
                else                     state_nxt_s = ST_ERR;
            end
`endif
            ST_RUN, ST_ERR: begin
                if (reload) state_nxt_s = ST_HDR0;
                else        state_nxt_s = state_r;
            end
            default: state_nxt_s = ST_HDR0;
        endcase
    end

    // State, status flags, header length and word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_HDR0;
            n_r         <= {HDR_W{1'b0}};
            wcnt_r      <= {(AW + 1){1'b0}};
            cpu_rst_r   <= 1'b1;
            load_done_r <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cpu_rst_r   <= (state_nxt_s != ST_RUN);
            load_done_r <= (state_nxt_s == ST_RUN);
            load_err_r  <= (state_nxt_s == ST_ERR);
            if ((state_nxt_s == ST_HDR0) && (state_r != ST_HDR0)) begin
                n_r    <= {HDR_W{1'b0}};
                wcnt_r <= {(AW + 1){1'b0}};
            end else if (accept_s && (state_r == ST_HDR0)) begin
                n_r[7:0] <= s_data;
            end else if (accept_s && (state_r == ST_HDR1)) begin
                n_r[15:8] <= s_data;
                wcnt_r    <= {(AW + 1){1'b0}};
            end else if (wr_en_s) begin
                wcnt_r <= wcnt_r + (AW + 1)'(1);
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR of payload bytes, restarted whenever a new image begins.
    always_ff @(posedge clk) begin
        if (rst || (state_nxt_s == ST_HDR0)) begin
            chk_r <= 8'h00;
        end else if (data_en_s) begin
            chk_r <= xor_fold(chk_r, s_data);
        end
    end
`endif

    // Word array; deliberately not cleared so a reload or reset keeps old contents.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wcnt_r[AW-1:0]] <= wr_data_s;
        end
    end

    // Instruction fetch, NOP outside RUN or beyond the array.
    always_comb begin
        if ((state_r == ST_RUN) && (PC[31:2] < PC_LIM)) begin
            instr_s = mem_r[PC[AW+1:2]];
        end else begin
            instr_s = NOP_INSTR;
        end
    end

    assign Instr     = instr_s;
    assign cpu_rst   = cpu_rst_r;
    assign load_done = load_done_r;
    assign load_err  = load_err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: reference memory model plus a queue of expected fetches.
module tb_imem_loader;

    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, s_valid, s_ready, reload, cpu_rst, load_done, load_err;
    logic [7:0]  s_data;
    logic [31:0] PC, Instr;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [31:0] mem_m [DEPTH];
    logic [31:0] img_w [DEPTH];
    logic [31:0] exp_q [$];
    bit          run_m;
    logic [31:0] word_a;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .reload    (reload),
        .PC        (PC),
        .Instr     (Instr),
        .cpu_rst   (cpu_rst),
        .load_done (load_done),
        .load_err  (load_err)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int gaps;
        if (stall) begin
            gaps = $urandom_range(0, 3);
            for (int i = 0; i < gaps; i++) begin
                @(negedge clk);
                s_valid = 1'b0;
                s_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 8'h00;
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        run_m  = 1'b0;
    endtask

    // Streams header, img_w[0..n-1] and (with the feature) a checksum byte.
    task automatic load_image(input int n, input bit stall, input bit corrupt);
        logic [15:0] nn;
        logic [7:0]  ck;
        logic [31:0] w;
        nn = 16'(n);
        ck = 8'h00;
        send_byte(nn[7:0], stall);
        send_byte(nn[15:8], stall);
        for (int i = 0; i < n; i++) begin
            w = img_w[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], stall);
                ck = ck ^ w[8*k +: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(corrupt ? (ck ^ 8'hFF) : ck, stall);
`endif
        idle();
        for (int i = 0; i < n; i++) mem_m[i] = img_w[i];
        run_m = !corrupt;
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] pc);
        logic [31:0] e;
        if (run_m && (pc[31:2] < 30'(DEPTH))) e = mem_m[pc[9:2]];
        else                                  e = NOP;
        exp_q.push_back(e);
        PC = pc;
        #1;
        check_value(tag, Instr, exp_q.pop_front());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; reload = 1'b0; PC = 32'h0; run_m = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_value("rst_cpu_rst", cpu_rst, 1);
        check_value("rst_done", load_done, 0);
        check_value("rst_err", load_err, 0);
        check_value("rst_ready", s_ready, 1);
        expect_instr("rst_instr", 32'h0);

        // Full-depth image
        for (int i = 0; i < DEPTH; i++) img_w[i] = $urandom;
        load_image(DEPTH, 1'b0, 1'b0);
        check_value("full_done", load_done, 1);
        check_value("full_cpu_rst", cpu_rst, 0);
        check_value("full_ready", s_ready, 0);
        expect_instr("full_pc0", 32'h0);
        expect_instr("full_pc3fc", 32'h3FC);
        expect_instr("full_pc3fe", 32'h3FE);
        expect_instr("full_pc400", 32'h400);
        expect_instr("full_pcmax", 32'hFFFF_FFFC);

        // Stray stream bytes in RUN are ignored
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = 8'($urandom);
        end
        idle();
        check_value("run_stray_done", load_done, 1);
        expect_instr("run_stray_pc10", 32'h10);

        pulse_reload();
        check_value("reload_cpu_rst", cpu_rst, 1);
        check_value("reload_ready", s_ready, 1);
        expect_instr("reload_instr", 32'h0);

        // Stalled N=4 load
        for (int i = 0; i < 4; i++) img_w[i] = $urandom;
        load_image(4, 1'b1, 1'b0);
        check_value("stall_done", load_done, 1);
        for (int i = 0; i < 5; i++) expect_instr("stall_word", 32'(i * 4));
        pulse_reload();

        // Basic two-word image, byte by byte
        send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h93, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h50, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'hA0, 1'b0);
        @(negedge clk);
        check_value("basic_cpu_rst_pre", cpu_rst, 1);
        s_valid = 1'b1;
        s_data  = 8'h00;
        @(posedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h93 ^ 8'h50 ^ 8'h13 ^ 8'h01 ^ 8'hA0, 1'b0);
`endif
        idle();
        check_value("basic_cpu_rst_run", cpu_rst, 0);
        mem_m[0] = 32'h0050_0093;
        mem_m[1] = 32'h00A0_0113;
        run_m = 1'b1;
        PC = 32'h0; #1;
        check_value("basic_mem0", Instr, 32'h0050_0093);
        PC = 32'h4; #1;
        check_value("basic_mem1", Instr, 32'h00A0_0113);
        expect_instr("basic_prior_mem2", 32'h8);
        pulse_reload();

`ifdef IMEM_LOADER_CHECKSUM_EN
        img_w[0] = 32'h0050_0093;
        img_w[1] = 32'h00A0_0113;
        load_image(2, 1'b0, 1'b1);
        check_value("badck_err", load_err, 1);
        check_value("badck_cpu_rst", cpu_rst, 1);
        pulse_reload();
`endif

        // Oversize header
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        idle();
        check_value("big_err", load_err, 1);
        check_value("big_ready", s_ready, 0);
        check_value("big_cpu_rst", cpu_rst, 1);
        expect_instr("big_instr", 32'h4);
        pulse_reload();
        check_value("err_reload_err", load_err, 0);
        check_value("err_reload_ready", s_ready, 1);

        // Zero-length image
        load_image(0, 1'b0, 1'b0);
        check_value("zero_cpu_rst", cpu_rst, 0);
        check_value("zero_done", load_done, 1);
        expect_instr("zero_pc3fc", 32'h3FC);
        expect_instr("zero_pc400", 32'h400);
        pulse_reload();

        // Reset after five payload bytes of an N=2 image
        word_a = $urandom;
        send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(word_a[8*k +: 8], 1'b0);
        send_byte(8'h5A, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        check_value("midrst_ready", s_ready, 1);
        check_value("midrst_cpu_rst", cpu_rst, 1);
        check_value("midrst_done", load_done, 0);
        mem_m[0] = word_a;
        load_image(0, 1'b0, 1'b0);
        expect_instr("midrst_mem0", 32'h0);
        expect_instr("midrst_mem1", 32'h4);
        pulse_reload();
        img_w[0] = $urandom;
        load_image(1, 1'b0, 1'b0);
        expect_instr("fresh_mem0", 32'h0);
        expect_instr("fresh_mem1", 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
